// File: rtl/f51m_seq_mult.sv
// Iterative radix-2 shift-add multiplier with optional signed mode and early termination.
// Sign is removed at accept, magnitudes are multiplied, and the sign is reapplied on the exit edge.
module f51m_seq_mult #(
  parameter int WIDTH      = 4,
  parameter int SIGNED_EN  = 1,
  parameter int EARLY_TERM = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             op_a,
  input  logic [WIDTH-1:0]             op_b,
  input  logic                         signed_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WIDTH-1:0]           result,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   last_iters
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W2-1:0]   a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [W2-1:0]   result_q, result_d;
  logic [CW-1:0]   last_iters_q, last_iters_d;

  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    acc_sum;
  logic [WIDTH-1:0] b_shift;
  logic [CW-1:0]    cnt_inc;
  logic             done_now;

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude
  assign sgn      = (SIGNED_EN != 0) & signed_mode;
  assign a_mag    = (sgn & op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag    = (sgn & op_b[WIDTH-1]) ? -op_b : op_b;
  assign acc_sum  = b_q[0] ? (acc_q + a_q) : acc_q;
  assign b_shift  = b_q >> 1;
  assign cnt_inc  = cnt_q + CW'(1);
  assign done_now = (cnt_inc == CW'(WIDTH)) | ((EARLY_TERM != 0) & (b_shift == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      result_q     <= '0;
      last_iters_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      neg_q        <= neg_d;
      result_q     <= result_d;
      last_iters_q <= last_iters_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    neg_d        = neg_q;
    result_d     = result_q;
    last_iters_d = last_iters_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = {{WIDTH{1'b0}}, a_mag};
          b_d   = b_mag;
          acc_d = '0;
          cnt_d = '0;
          neg_d = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          if ((EARLY_TERM != 0) && (b_mag == '0)) begin
            state_d      = S_DONE;
            result_d     = '0;
            last_iters_d = '0;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_shift;
        cnt_d = cnt_inc;
        if (done_now) begin
          state_d      = S_DONE;
          result_d     = neg_q ? -acc_sum : acc_sum;
          last_iters_d = cnt_inc;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q == S_BUSY);
  assign out_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign last_iters = last_iters_q;

endmodule
